// File: rtl/echo_rx_pkg.sv
// Shared constants for the echo receive-window timer.
// The effective filter length depends on ECHO_RX_GLITCH_FILT_EN.
package echo_rx_pkg;

    localparam logic [3:0] S_IDLE   = 4'b0001;
    localparam logic [3:0] S_BLANK  = 4'b0010;
    localparam logic [3:0] S_LISTEN = 4'b0100;
    localparam logic [3:0] S_DONE   = 4'b1000;

    localparam int unsigned BLANK_CYC_DEF   = 100;
    localparam int unsigned TIMEOUT_CYC_DEF = 1_000_000;
    localparam int unsigned FILT_LEN_DEF    = 4;

    function automatic int unsigned eff_filt_len(input int unsigned filt_len);
        int unsigned len;
        len = filt_len;
`ifndef ECHO_RX_GLITCH_FILT_EN
        len = 1; // without the glitch filter a single armed high qualifies
`endif
        return len;
    endfunction

endpackage

// File: rtl/echo_rx_filt.sv
// Echo qualifier: 2-flop synchronizer, arm-on-low flag and consecutive-high counter.
// The run-length requirement is FILT_LEN only when ECHO_RX_GLITCH_FILT_EN is defined.
module echo_rx_filt
    import echo_rx_pkg::*;
#(
    parameter int unsigned FILT_LEN = FILT_LEN_DEF
) (
    input  logic clk_100,
    input  logic rst,
    input  logic clr,
    input  logic echo_in,
    output logic echo_hit
);

    localparam int unsigned FLEN  = eff_filt_len(FILT_LEN);
    localparam int unsigned RUN_W = $clog2(FLEN + 1);

    logic             sync1_q, sync2_q;
    logic             armed_q, armed_d;
    logic             hit_q, hit_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             qual;

    assign qual = armed_q & sync2_q & (run_q == RUN_W'(FLEN - 1));

    always_comb begin
        armed_d = armed_q;
        run_d   = run_q;
        hit_d   = hit_q;
        if (clr) begin
            armed_d = 1'b0;
            run_d   = '0;
            hit_d   = 1'b0;
        end else begin
            if (!sync2_q) begin
                armed_d = 1'b1;
                run_d   = '0;
            end else if (armed_q && !qual) begin
                run_d = run_q + RUN_W'(1);
            end
            if (qual) begin
                hit_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            armed_q <= 1'b0;
            run_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            sync1_q <= echo_in;
            sync2_q <= sync1_q;
            armed_q <= armed_d;
            run_q   <= run_d;
            hit_q   <= hit_d;
        end
    end

    // Qualification is visible in the same cycle so the top latches the exact count.
    assign echo_hit = hit_q | (qual & ~clr);

endmodule

// File: rtl/echo_rx.sv
// Receive-window timer: blanking, echo time-of-flight measurement and no-echo timeout.
// ECHO_RX_GLITCH_FILT_EN enables the FILT_LEN consecutive-sample echo filter.
module echo_rx
    import echo_rx_pkg::*;
#(
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned BLANK_CYC   = BLANK_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned FILT_LEN    = FILT_LEN_DEF
) (
    input  logic             clk_100,
    input  logic             rst,
    input  logic             enRe,
    input  logic             echo_in,
    output logic             overRe,
    output logic [CNT_W-1:0] tof_cnt,
    output logic             tof_valid,
    output logic             timeout
);

    localparam int unsigned      FLEN       = eff_filt_len(FILT_LEN);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] QUAL_OFS   = CNT_W'(FLEN - 1);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tof_q, tof_d;
    logic             valid_q, valid_d;
    logic             to_q, to_d;
    logic             over_q, over_d;
    logic             echo_hit;

    echo_rx_filt #(
        .FILT_LEN (FILT_LEN)
    ) u_filt (
        .clk_100  (clk_100),
        .rst      (rst),
        .clr      (state_q != S_LISTEN),
        .echo_in  (echo_in),
        .echo_hit (echo_hit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tof_d   = tof_q;
        valid_d = valid_q;
        to_d    = to_q;
        unique case (state_q)
            S_IDLE: begin
                if (enRe) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    to_d    = 1'b0;
                end
            end
            S_BLANK: begin
                if (!enRe) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == BLANK_LAST) begin
                        state_d = S_LISTEN;
                    end
                end
            end
            S_LISTEN: begin
                if (!enRe) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // An echo on the final window cycle still beats the timeout.
                    if (echo_hit) begin
                        tof_d   = cnt_q - QUAL_OFS;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end else if (cnt_q == TO_LAST) begin
                        to_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!enRe) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        over_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tof_q   <= '0;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tof_q   <= tof_d;
            valid_q <= valid_d;
            to_q    <= to_d;
            over_q  <= over_d;
        end
    end

    assign overRe    = over_q;
    assign tof_cnt   = tof_q;
    assign tof_valid = valid_q;
    assign timeout   = to_q;

endmodule

// File: tb/tb_echo_rx.sv
// Randomized and directed bench for echo_rx against a per-window behavioural model.
// The model follows ECHO_RX_GLITCH_FILT_EN the same way the design does.
module tb_echo_rx;

    localparam int CNT_W   = 20;
    localparam int BLANK   = 10;
    localparam int TIMEOUT = 200;
    localparam int FILT    = 4;
`ifdef ECHO_RX_GLITCH_FILT_EN
    localparam int F_EFF = FILT;
`else
    localparam int F_EFF = 1;
`endif
    localparam int NO_ABORT = 1000;

    logic             clk_100 = 1'b0;
    logic             rst     = 1'b1;
    logic             enRe    = 1'b0;
    logic             echo_in = 1'b0;
    logic             overRe;
    logic [CNT_W-1:0] tof_cnt;
    logic             tof_valid;
    logic             timeout;

    int n_vec = 0;
    int n_err = 0;

    // Echo level driven during window cycle k (counter value k).
    logic e_arr [0:299];

    int exp_tof   = 0;
    int exp_valid = 0;
    int exp_to    = 0;

    echo_rx #(
        .CNT_W       (CNT_W),
        .BLANK_CYC   (BLANK),
        .TIMEOUT_CYC (TIMEOUT),
        .FILT_LEN    (FILT)
    ) dut (
        .clk_100   (clk_100),
        .rst       (rst),
        .enRe      (enRe),
        .echo_in   (echo_in),
        .overRe    (overRe),
        .tof_cnt   (tof_cnt),
        .tof_valid (tof_valid),
        .timeout   (timeout)
    );

    always #5 clk_100 = ~clk_100;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic fill(input int lo, input int hi, input logic lvl);
        for (int i = lo; i <= hi; i++) e_arr[i] = lvl;
    endtask

    // Window outcome from the rules: sync delay 2, arm on a low seen while listening,
    // F_EFF armed highs in a row qualify; kind 0 = aborted, 1 = echo, 2 = timeout.
    function automatic void model(input int abort_k, output int kind, output int k_end,
                                  output int tof);
        bit armed = 0;
        int run   = 0;
        kind  = 0;
        k_end = abort_k;
        tof   = 0;
        for (int k = 0; k < TIMEOUT; k++) begin
            logic s;
            if (k >= abort_k) return;
            if (k < BLANK) continue;
            s = e_arr[k-2];
            if (armed && s) run++;
            else run = 0;
            if (!s) armed = 1;
            if (run >= F_EFF) begin
                kind = 1; k_end = k; tof = k - (F_EFF - 1);
                return;
            end
            if (k == TIMEOUT - 1) begin
                kind = 2; k_end = k;
                return;
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, "_tof"}, 32'(tof_cnt), exp_tof);
        check_eq({tag, "_valid"}, 32'(tof_valid), exp_valid);
        check_eq({tag, "_timeout"}, 32'(timeout), exp_to);
    endtask

    task automatic run_window(input int abort_k, input int want_tof, input int rst_k);
        int kind, k_end, tof, done_k, last;
        model(abort_k, kind, k_end, tof);
        done_k = (kind != 0) ? k_end + 1 : -1;
        last   = (kind != 0) ? done_k + 1 : abort_k;
        @(posedge clk_100); #1;
        enRe    = 1'b1;
        echo_in = e_arr[0];
        exp_valid = 0;
        exp_to    = 0;
        for (int k = 0; k <= last; k++) begin
            @(posedge clk_100); #1;
            echo_in = e_arr[k];
            enRe    = (kind != 0) ? (k <= done_k) : (k < abort_k);
            if (k == rst_k) begin
                rst = 1'b1;
                #1;
                exp_tof = 0; exp_valid = 0; exp_to = 0;
                check_eq("rst_mid_overRe", 32'(overRe), 0);
                check_outputs("rst_mid");
                rst  = 1'b0;
                enRe = 1'b0;
                break;
            end
            @(negedge clk_100);
            if (k == 0) begin
                check_eq("start_valid", 32'(tof_valid), 0);
                check_eq("start_timeout", 32'(timeout), 0);
            end
            check_eq("overRe", 32'(overRe), 32'(k == done_k));
            if (k == done_k) begin
                if (kind == 1) begin
                    exp_tof = tof; exp_valid = 1; exp_to = 0;
                end else begin
                    exp_valid = 0; exp_to = 1;
                end
                check_outputs("done");
                if (want_tof >= 0) check_eq("tof_plan", 32'(tof_cnt), want_tof);
            end
        end
        @(posedge clk_100); #1;
        enRe    = 1'b0;
        echo_in = 1'b0;
        @(negedge clk_100);
        check_eq("idle_overRe", 32'(overRe), 0);
        check_outputs("idle");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check_eq("reset_overRe", 32'(overRe), 0);
        check_outputs("reset");
        @(posedge clk_100); #1;
        rst = 1'b0;

        // Basic echo: high from counter 50.
        fill(0, 299, 0); fill(50, 299, 1);
        run_window(NO_ABORT, 52, -1);
        // Timeout: no echo, tof_cnt keeps its previous value.
        fill(0, 299, 0);
        run_window(NO_ABORT, -1, -1);
        // Ringing across window start, then a real echo.
        fill(0, 299, 0); fill(0, 30, 1); fill(60, 299, 1);
        run_window(NO_ABORT, 62, -1);
        // Glitch of 3 cycles, then sustained echo.
        fill(0, 299, 0); fill(40, 42, 1); fill(80, 299, 1);
`ifdef ECHO_RX_GLITCH_FILT_EN
        run_window(NO_ABORT, 82, -1);
`else
        run_window(NO_ABORT, 42, -1);
`endif
        // Abort at counter 20, then a normal window.
        fill(0, 299, 0); fill(50, 299, 1);
        run_window(20, -1, -1);
        run_window(NO_ABORT, 52, -1);
        // Reset mid-listen, then a normal window.
        fill(0, 299, 0);
        run_window(NO_ABORT, -1, 100);
        fill(0, 299, 0); fill(70, 299, 1);
        run_window(NO_ABORT, 72, -1);

        // Randomized windows: segmented noise, occasional quiet line or abort.
        for (int w = 0; w < 24; w++) begin
            int seg, ab;
            logic lvl;
            lvl = 1'($urandom_range(0, 1));
            seg = 0;
            for (int i = 0; i < 300; i++) begin
                if (seg == 0) begin
                    lvl = ~lvl;
                    seg = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 60)
                                                       : $urandom_range(1, 6);
                end
                e_arr[i] = lvl;
                seg--;
            end
            if ($urandom_range(0, 4) == 0) fill(0, 299, 0);
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 190) : NO_ABORT;
            run_window(ab, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
